// File: rtl/me_fullsearch_param.sv
// rtl/me_fullsearch_param.sv - full-search block-matching motion estimator with optional early termination
module me_fullsearch_param #(
    parameter int PEL_W = 8,
    parameter int BLK   = 4,
    parameter int RANGE = 4,
    localparam int SW    = BLK + 2*RANGE,
    localparam int SAD_W = PEL_W + $clog2(BLK*BLK),
    localparam int MV_W  = $clog2(2*RANGE+1) + 1,
    localparam int SWA_W = $clog2(SW*SW),
    localparam int TBA_W = $clog2(BLK*BLK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             early_term,
    output logic             ack,
    output logic             busy,
    output logic [SAD_W-1:0] min_sad,
    output logic [MV_W-1:0]  min_mvec_h,
    output logic [MV_W-1:0]  min_mvec_w,
    output logic [SWA_W-1:0] addr_sw,
    input  logic [PEL_W-1:0] pel_sw,
    output logic [TBA_W-1:0] addr_tb,
    input  logic [PEL_W-1:0] pel_tb
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DW = MV_W - 1;
    localparam int PW = $clog2(BLK);
    localparam logic [DW-1:0] D_MAX = DW'(2*RANGE);
    localparam logic [PW-1:0] P_MAX = PW'(BLK-1);

    logic [1:0]       state;
    logic [DW-1:0]    dy, dx;
    logic [PW-1:0]    y, x;
    logic             et_lat, min_valid;

    logic             s1_valid, s1_first, s1_last;
    logic [DW-1:0]    s1_dy, s1_dx;

    logic [SAD_W-1:0] acc;
    logic             acc_live, cmp_pending;
    logic [DW-1:0]    acc_dy, acc_dx;

    logic [PEL_W-1:0] diff;
    logic             pix_last, cand_last, abort;

    assign ack  = (state == S_DONE);
    assign busy = (state == S_RUN) || (state == S_DRAIN);

    assign addr_sw = (state == S_RUN)
                   ? (SWA_W'(dy) + SWA_W'(y)) * SWA_W'(SW) + SWA_W'(dx) + SWA_W'(x)
                   : '0;
    assign addr_tb = (state == S_RUN) ? {y, x} : '0;

    // Abort only while the partial SAD belongs to the candidate still being
    // addressed; once its last pixel is in flight it simply finishes normally.
    always_comb begin
        pix_last  = (y == P_MAX) && (x == P_MAX);
        cand_last = (dy == D_MAX) && (dx == D_MAX);
        diff      = (pel_sw >= pel_tb) ? (pel_sw - pel_tb) : (pel_tb - pel_sw);
        abort     = (state == S_RUN) && et_lat && min_valid && acc_live
                 && !(s1_valid && s1_last) && (acc >= min_sad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dy          <= '0;
            dx          <= '0;
            y           <= '0;
            x           <= '0;
            et_lat      <= 1'b0;
            min_valid   <= 1'b0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_dy       <= '0;
            s1_dx       <= '0;
            acc         <= '0;
            acc_live    <= 1'b0;
            cmp_pending <= 1'b0;
            acc_dy      <= '0;
            acc_dx      <= '0;
            min_sad     <= '0;
            min_mvec_h  <= '0;
            min_mvec_w  <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    state     <= S_RUN;
                    dy        <= '0;
                    dx        <= '0;
                    y         <= '0;
                    x         <= '0;
                    et_lat    <= early_term;
                    min_valid <= 1'b0;
                end
                S_RUN: begin
                    if (abort || pix_last) begin
                        y <= '0;
                        x <= '0;
                        if (cand_last) begin
                            state <= S_DRAIN;
                        end else if (dx == D_MAX) begin
                            dx <= '0;
                            dy <= dy + 1'b1;
                        end else begin
                            dx <= dx + 1'b1;
                        end
                    end else if (x == P_MAX) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                S_DRAIN: if (!s1_valid) state <= S_DONE;
                S_DONE:  if (!req) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Stage 1 tags the read issued this cycle; its data arrives next cycle.
            s1_valid <= (state == S_RUN) && !abort;
            s1_first <= (y == '0) && (x == '0);
            s1_last  <= pix_last;
            s1_dy    <= dy;
            s1_dx    <= dx;

            if (s1_valid && !abort) begin
                acc      <= (s1_first ? '0 : acc) + SAD_W'(diff);
                acc_live <= !s1_last;
                acc_dy   <= s1_dy;
                acc_dx   <= s1_dx;
            end else if (abort) begin
                acc_live <= 1'b0;
            end
            cmp_pending <= s1_valid && !abort && s1_last;

            // Strictly-less keeps the earliest raster candidate on ties.
            if (cmp_pending && (!min_valid || (acc < min_sad))) begin
                min_sad    <= acc;
                min_mvec_h <= MV_W'(acc_dy) - MV_W'(RANGE);
                min_mvec_w <= MV_W'(acc_dx) - MV_W'(RANGE);
                min_valid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_me_fullsearch_param.sv
// tb/tb_me_fullsearch_param.sv - directed and seeded-random checks for me_fullsearch_param
module tb_me_fullsearch_param;
    localparam int PEL_W = 8;
    localparam int BLK   = 4;
    localparam int RANGE = 4;
    localparam int SW    = BLK + 2*RANGE;
    localparam int SAD_W = 12;
    localparam int MV_W  = 5;
    localparam int SWA_W = 8;
    localparam int TBA_W = 4;
    localparam int FULL_LAT = 1298;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic             early_term;
    logic             ack;
    logic             busy;
    logic [SAD_W-1:0] min_sad;
    logic [MV_W-1:0]  min_mvec_h;
    logic [MV_W-1:0]  min_mvec_w;
    logic [SWA_W-1:0] addr_sw;
    logic [PEL_W-1:0] pel_sw;
    logic [TBA_W-1:0] addr_tb;
    logic [PEL_W-1:0] pel_tb;

    logic [PEL_W-1:0] sw_mem [0:SW*SW-1];
    logic [PEL_W-1:0] tb_mem [0:BLK*BLK-1];

    int n_checks = 0;
    int n_fail   = 0;

    me_fullsearch_param #(.PEL_W(PEL_W), .BLK(BLK), .RANGE(RANGE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .early_term (early_term),
        .ack        (ack),
        .busy       (busy),
        .min_sad    (min_sad),
        .min_mvec_h (min_mvec_h),
        .min_mvec_w (min_mvec_w),
        .addr_sw    (addr_sw),
        .pel_sw     (pel_sw),
        .addr_tb    (addr_tb),
        .pel_tb     (pel_tb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pel_sw <= sw_mem[addr_sw];
        pel_tb <= tb_mem[addr_tb];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mvh();
        return int'($signed(min_mvec_h));
    endfunction

    function automatic int mvw();
        return int'($signed(min_mvec_w));
    endfunction

    task automatic fill_sw_random(input int maxv);
        for (int i = 0; i < SW*SW; i++) sw_mem[i] = PEL_W'($urandom_range(0, maxv));
    endtask

    task automatic fill_tb_random(input int maxv);
        for (int i = 0; i < BLK*BLK; i++) tb_mem[i] = PEL_W'($urandom_range(0, maxv));
    endtask

    task automatic fill_const(input int swv, input int tbv);
        for (int i = 0; i < SW*SW; i++) sw_mem[i] = PEL_W'(swv);
        for (int i = 0; i < BLK*BLK; i++) tb_mem[i] = PEL_W'(tbv);
    endtask

    task automatic load_match_data();
        fill_sw_random(255);
        for (int yy = 0; yy < BLK; yy++)
            for (int xx = 0; xx < BLK; xx++)
                tb_mem[yy*BLK+xx] = sw_mem[(6+yy)*SW + 2 + xx];
    endtask

    // Straightforward exhaustive search with earliest-candidate tie rule.
    task automatic ref_search(output int rs, output int rh, output int rw);
        int best;
        int s;
        int d;
        best = -1;
        rh = 0;
        rw = 0;
        for (int dy = 0; dy <= 2*RANGE; dy++)
            for (int dx = 0; dx <= 2*RANGE; dx++) begin
                s = 0;
                for (int yy = 0; yy < BLK; yy++)
                    for (int xx = 0; xx < BLK; xx++) begin
                        d = int'(sw_mem[(dy+yy)*SW + dx + xx]) - int'(tb_mem[yy*BLK+xx]);
                        s += (d < 0) ? -d : d;
                    end
                if (best < 0 || s < best) begin
                    best = s;
                    rh = dy - RANGE;
                    rw = dx - RANGE;
                end
            end
        rs = best;
    endtask

    task automatic run_search(input logic et, output int lat);
        @(negedge clk);
        req = 1'b1;
        early_term = et;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("busy_in_run", int'(busy), 1);
            if (ack) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_drop", int'(ack), 0);
    endtask

    initial begin
        int lat, lat_e;
        int rs, rh, rw;
        int fs, fh, fw;
        int dummy;

        rst = 1'b1;
        req = 1'b0;
        early_term = 1'b0;
        fill_const(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_min_sad", int'(min_sad), 0);
        check("rst_mvh", mvh(), 0);
        check("rst_mvw", mvw(), 0);
        check("rst_addr_sw", int'(addr_sw), 0);
        check("rst_addr_tb", int'(addr_tb), 0);
        @(negedge clk);
        rst = 1'b0;

        dummy = $urandom(32'd777);
        load_match_data();
        run_search(1'b0, lat);
        check("match_lat", lat, FULL_LAT);
        check("match_sad", int'(min_sad), 0);
        check("match_mvh", mvh(), 2);
        check("match_mvw", mvw(), -2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("ack_hold", int'(ack), 1);
        end
        release_req();
        run_search(1'b0, lat);
        check("restart_lat", lat, FULL_LAT);
        check("restart_sad", int'(min_sad), 0);
        release_req();

        run_search(1'b1, lat_e);
        check("et_match_faster", int'(lat_e > 0 && lat_e < FULL_LAT), 1);
        check("et_match_sad", int'(min_sad), 0);
        check("et_match_mvh", mvh(), 2);
        check("et_match_mvw", mvw(), -2);
        release_req();

        fill_const(5, 0);
        run_search(1'b0, lat);
        check("flat_sad", int'(min_sad), 80);
        check("flat_mvh", mvh(), -4);
        check("flat_mvw", mvw(), -4);
        release_req();

        fill_const(0, 255);
        run_search(1'b0, lat);
        check("max_sad", int'(min_sad), 4080);
        check("max_mvh", mvh(), -4);
        check("max_mvw", mvw(), -4);
        release_req();

        fill_const(5, 0);
        @(negedge clk);
        req = 1'b1;
        early_term = 1'b0;
        @(posedge clk);
        repeat (499) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_min", int'(min_sad), 80);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ack", int'(ack), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_min", int'(min_sad), 0);
        check("midrst_mvh", mvh(), 0);
        check("midrst_addr_sw", int'(addr_sw), 0);
        @(negedge clk);
        rst = 1'b0;
        load_match_data();
        run_search(1'b0, lat);
        check("post_rst_lat", lat, FULL_LAT);
        check("post_rst_sad", int'(min_sad), 0);
        check("post_rst_mvh", mvh(), 2);
        check("post_rst_mvw", mvw(), -2);
        release_req();

        // Odd seeds use a tiny pixel range so equal SADs and tie handling get exercised.
        for (int s = 0; s < 20; s++) begin
            dummy = $urandom(32'd1000 + s);
            fill_sw_random((s % 2) ? 3 : 255);
            fill_tb_random((s % 2) ? 3 : 255);
            ref_search(rs, rh, rw);
            run_search(1'b0, lat);
            check("rnd_full_lat", lat, FULL_LAT);
            check("rnd_full_sad", int'(min_sad), rs);
            check("rnd_full_mvh", mvh(), rh);
            check("rnd_full_mvw", mvw(), rw);
            fs = int'(min_sad);
            fh = mvh();
            fw = mvw();
            release_req();
            run_search(1'b1, lat_e);
            check("rnd_et_lat", int'(lat_e > 0 && lat_e <= FULL_LAT), 1);
            check("rnd_et_sad", int'(min_sad), fs);
            check("rnd_et_mvh", mvh(), fh);
            check("rnd_et_mvw", mvw(), fw);
            release_req();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/me_fullsearch_param.md
ME_FULLSEARCH_PARAM -- requirements
Module: me_fullsearch_param

Interface
REQ-001 Parameter PEL_W, default 8: pixel bit width.
REQ-002 Parameter BLK, default 4: template block edge, BLKxBLK pixels, power of two >= 2.
REQ-003 Parameter RANGE, default 4: search range +/-RANGE in both axes; search window edge SW = BLK+2*RANGE.
REQ-004 Derived: SAD_W = PEL_W+clog2(BLK*BLK); MV_W = clog2(2*RANGE+1)+1; SWA_W = clog2(SW*SW); TBA_W = clog2(BLK*BLK).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  1  level request; search starts when sampled high in IDLE.
REQ-008 early_term  in  1  early-termination mode, sampled with accepted req.
REQ-009 ack  out  1  result valid / search done.
REQ-010 busy  out  1  high in RUN and DRAIN.
REQ-011 min_sad  out  SAD_W  minimum SAD of last search.
REQ-012 min_mvec_h / min_mvec_w  out  MV_W each  signed two's-complement vertical/horizontal vector, range -RANGE..+RANGE.
REQ-013 addr_sw  out  SWA_W  search-window address, row-major, (row*SW+col).
REQ-014 pel_sw  in  PEL_W  search-window pixel, valid one edge after addr_sw (registered memory).
REQ-015 addr_tb  out  TBA_W  template address, row-major, (y*BLK+x).
REQ-016 pel_tb  in  PEL_W  template pixel, same one-cycle read latency.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on req=1; RUN->DRAIN after last address; DRAIN->DONE after last compare; DONE->IDLE when req=0.
REQ-018 Candidate order raster: dy outer 0..2*RANGE, dx inner 0..2*RANGE; pixel order y outer, x inner; one address pair per cycle in RUN.
REQ-019 addr_sw = (dy+y)*SW+(dx+x); addr_tb = y*BLK+x; both 0 outside RUN.
REQ-020 Pipeline valid bit and last-pixel flag accompany each read; accumulator adds |pel_sw-pel_tb| one edge after address issue, cleared at each candidate start.
REQ-021 Candidate SAD compared on the edge after its last pixel accumulates; min updated only if strictly less, or if candidate is first; ties keep earlier candidate.
REQ-022 Stored vector = (dy-RANGE, dx-RANGE); min_sad/min_mvec registers update only as REQ-021, hold through DONE and IDLE until next accepted req.
REQ-023 Full-search latency: ack rises on rising edge N*BLK*BLK+2 after the accepting edge, N=(2*RANGE+1)^2 (default 1298).
REQ-024 Early term (early_term latched 1): when accumulated partial SAD >= stored min and candidate not first, next cycle issues first pixel of next candidate; in-flight read of aborted candidate discarded (valid cleared), never accumulated.
REQ-025 Early-term result (min_sad, vectors) shall be bit-identical to full search on same data; latency <= REQ-023.
REQ-026 No overflow: accumulator SAD_W bits holds BLK*BLK*(2^PEL_W-1).
REQ-027 ack=1 throughout DONE (at least one cycle), else 0; req dropped during RUN/DRAIN ignored, search completes, DONE lasts one cycle.
REQ-028 req held high in DONE keeps ack high; no restart until req seen low in DONE.

Reset
REQ-029 rst=1 at any edge, including mid-RUN: state IDLE, ack=0, busy=0, min_sad=0, min_mvec_h=0, min_mvec_w=0, addr_sw=0, addr_tb=0, accumulator and pipeline valid cleared, early_term latch 0.
REQ-030 First req after reset release behaves as REQ-023 with no residue of aborted search.

Verification (defaults PEL_W=8, BLK=4, RANGE=4)
REQ-031 TB equals SW sub-block at row 6, col 2, rest random -> min_sad=0, mvec_h=+2, mvec_w=-2, ack at edge 1298.
REQ-032 TB all 0, SW all 5 -> all SADs 80, tie rule -> min_sad=80, mvec_h=-4, mvec_w=-4.
REQ-033 TB all 255, SW all 0 -> min_sad=4080, mvec (-4,-4), no wrap.
REQ-034 REQ-031 data with early_term=1 -> identical outputs, ack before edge 1298; random data, 20 seeds, early vs full outputs equal.
REQ-035 rst pulsed at edge 500 of a search -> next edge ack=0, busy=0, min_sad=0; new req completes per REQ-031.
REQ-036 req held 10 cycles after ack -> ack stays 1; req dropped -> ack 0 next edge; req reasserted -> new search, ack after 1298 edges.
